// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Sweep FSM encoding, zero-register address and grant-index width helper.
package regfile_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int REG_ZERO = 0;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Write-back requester bundle: per-requester valid/addr/data, one-hot ready.
// master = requesters, slave = arbiter.
interface regfile_write_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]      req_data;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid index at or after ptr,
// wrapping modulo NUM_REQ; one-hot grant plus its index.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    localparam int IDW    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               any_valid
);

    int             sum;
    logic [IDW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = |valid;
        sum       = 0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDW'(sum);
            if (valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ requesters.
// Define REGFILE_ARB_INIT_SWEEP_EN to zero every register after reset first.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    localparam int IDW       = clog2_min1(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_write_arbiter_if.slave req_if,
    output logic                   regWrite,
    output logic [ADDR_WIDTH-1:0]  writeAddr,
    output logic [WIDTH-1:0]       writeData,
    output logic [IDW-1:0]         grant_id,
    output logic                   init_done
);

    logic [NUM_REQ-1:0]    grant;
    logic [IDW-1:0]        grant_idx;
    logic                  any_valid;
    logic                  run;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_data;

    state_e                state_q;
    state_e                state_d;
    logic                  sweep_wr;
    logic [ADDR_WIDTH-1:0] sweep_addr;

    logic [IDW-1:0]        ptr_q;
    logic [IDW-1:0]        ptr_d;
    logic                  regwrite_q;
    logic                  regwrite_d;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [WIDTH-1:0]      wdata_q;
    logic [WIDTH-1:0]      wdata_d;
    logic [IDW-1:0]        gid_q;
    logic [IDW-1:0]        gid_d;
    logic                  init_done_q;
    logic                  init_done_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .valid     (req_if.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

`ifdef REGFILE_ARB_INIT_SWEEP_EN
    // Extra MSB marks "all addresses issued"; RUN follows once the
    // last sweep write has been on the port for its cycle.
    logic [ADDR_WIDTH:0] sweep_cnt_q;
    logic [ADDR_WIDTH:0] sweep_cnt_d;

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        sweep_wr    = 1'b0;
        if (state_q == ST_INIT) begin
            if (sweep_cnt_q[ADDR_WIDTH]) begin
                state_d = ST_RUN;
            end else begin
                sweep_wr    = 1'b1;
                sweep_cnt_d = sweep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
        end
    end

    assign sweep_addr = sweep_cnt_q[ADDR_WIDTH-1:0];
`else
    assign state_q    = ST_RUN;
    assign state_d    = ST_RUN;
    assign sweep_wr   = 1'b0;
    assign sweep_addr = '0;
`endif

    assign run              = (state_q == ST_RUN);
    assign req_if.req_ready = run ? grant : '0;
    assign accept           = run & any_valid;

    assign sel_addr =
        req_if.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_data =
        req_if.req_data[int'(grant_idx)*WIDTH +: WIDTH];

    always_comb begin
        regwrite_d  = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        gid_d       = gid_q;
        ptr_d       = ptr_q;
        init_done_d = (state_d == ST_RUN);
        unique case (1'b1)
            sweep_wr: begin
                regwrite_d = 1'b1;
                waddr_d    = sweep_addr;
                wdata_d    = '0;
            end
            accept: begin
                // x0 is hardwired: the transfer completes but no write issues.
                regwrite_d = (sel_addr != ADDR_WIDTH'(REG_ZERO));
                waddr_d    = sel_addr;
                wdata_d    = sel_data;
                gid_d      = grant_idx;
                if (grant_idx == IDW'(NUM_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = grant_idx + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            regwrite_q  <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            gid_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            regwrite_q  <= regwrite_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            gid_q       <= gid_d;
            init_done_q <= init_done_d;
        end
    end

    assign regWrite  = regwrite_q;
    assign writeAddr = waddr_q;
    assign writeData = wdata_q;
    assign grant_id  = gid_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: per-cycle model compare plus directed literals.
// Sweep scenarios run only when REGFILE_ARB_INIT_SWEEP_EN is defined.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          regWrite;
    logic [AW-1:0] writeAddr;
    logic [W-1:0]  writeData;
    logic [1:0]    grant_id;
    logic          init_done;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_write_arbiter_if #(
        .NUM_REQ (N), .WIDTH (W), .ADDR_WIDTH (AW)
    ) rif ();

    regfile_write_arbiter #(
        .NUM_REQ (N), .WIDTH (W), .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_if    (rif),
        .regWrite  (regWrite),
        .writeAddr (writeAddr),
        .writeData (writeData),
        .grant_id  (grant_id),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Spec-level winner: smallest circular distance from the pointer.
    function automatic int winner(input logic [N-1:0] v, input int p);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = N;
        for (int i = 0; i < N; i++) begin
            d = (i - p + N) % N;
            if (v[i] && d < bd) begin
                bd   = d;
                best = i;
            end
        end
        return best;
    endfunction

    int            m_ptr;
    bit            m_run;
    bit            m_we;
    bit            m_init;
    bit            m_known;
    int            m_sw;
    int            m_gid;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_data;

    always @(posedge clk or negedge reset_n) begin : model
        int w;
        if (!reset_n) begin
            m_ptr   = 0;
            m_we    = 0;
            m_addr  = '0;
            m_data  = '0;
            m_gid   = 0;
            m_init  = 0;
            m_known = 1;
            m_sw    = 0;
`ifdef REGFILE_ARB_INIT_SWEEP_EN
            m_run   = 0;
`else
            m_run   = 1;
`endif
        end else if (!m_run) begin
            if (m_sw < (1 << AW)) begin
                m_we    = 1;
                m_addr  = AW'(m_sw);
                m_data  = '0;
                m_known = 1;
                m_sw++;
            end else begin
                m_we   = 0;
                m_run  = 1;
                m_init = 1;
            end
        end else begin
            m_init = 1;
            w = winner(rif.req_valid, m_ptr);
            if (w < 0) begin
                m_we = 0;
            end else begin
                m_addr  = rif.req_addr[w*AW +: AW];
                m_data  = rif.req_data[w*W +: W];
                m_gid   = w;
                m_ptr   = (w + 1) % N;
                m_we    = (m_addr != 0);
                m_known = m_we;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [N-1:0] er;
        int w;
        if (reset_n) begin
            er = '0;
            if (m_run) begin
                w = winner(rif.req_valid, m_ptr);
                if (w >= 0) er[w] = 1'b1;
            end
            chk("m_ready", rif.req_ready, er);
            chk("m_regWrite", regWrite, m_we);
            chk("m_grant_id", grant_id, m_gid);
            chk("m_init_done", init_done, m_init);
            if (m_known) begin
                chk("m_writeAddr", writeAddr, m_addr);
                chk("m_writeData", writeData, m_data);
            end
        end
    end

    logic [W-1:0] rf [1 << AW];

    always @(posedge clk) begin
        if (regWrite) rf[writeAddr] <= writeData;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
        rif.req_valid[i]        = v;
        rif.req_addr[i*AW +: AW] = a;
        rif.req_data[i*W +: W]   = d;
    endtask

    task automatic chk_wr(input string name, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic [1:0] g);
        chk({name, "_we"}, regWrite, 1'b1);
        chk({name, "_addr"}, writeAddr, a);
        chk({name, "_data"}, writeData, d);
        chk({name, "_gid"}, grant_id, g);
    endtask

    int g_seq [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        int  exp_a;
        bit  hit;
        rif.req_valid = '0;
        rif.req_addr  = '0;
        rif.req_data  = '0;
        reset_n       = 1'b0;
        repeat (3) tick();
        chk("rst_we", regWrite, 1'b0);
        chk("rst_addr", writeAddr, '0);
        chk("rst_data", writeData, '0);
        chk("rst_gid", grant_id, '0);
        chk("rst_init", init_done, 1'b0);

`ifdef REGFILE_ARB_INIT_SWEEP_EN
        drive(0, 1'b1, 5'd1, 32'hA0);
        drive(1, 1'b1, 5'd2, 32'hA1);
        drive(2, 1'b1, 5'd3, 32'hA2);
        reset_n = 1'b1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            chk("sw6_ready", rif.req_ready, 3'b000);
            if (regWrite && writeAddr == 5'd10) hit = 1;
        end
        chk("sw6_reach10", hit, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("sw6_rst_we", regWrite, 1'b0);
        chk("sw6_rst_addr", writeAddr, '0);
        chk("sw6_rst_init", init_done, 1'b0);
        tick();
        reset_n = 1'b1;
        exp_a = 0;
        for (int i = 0; i < 60 && !init_done; i++) begin
            tick();
            if (!init_done) begin
                chk("sw1_ready", rif.req_ready, 3'b000);
                if (regWrite) begin
                    chk("sw1_addr", writeAddr, AW'(exp_a));
                    chk("sw1_data", writeData, '0);
                    exp_a++;
                end
            end
        end
        chk("sw1_count", exp_a, 32);
        chk("sw1_init", init_done, 1'b1);
        chk("sw1_ready_run", rif.req_ready, 3'b001);
        tick();
        rif.req_valid = '0;
        #1;
        chk_wr("sw1_first", 5'd1, 32'hA0, 2'd0);
`else
        reset_n = 1'b1;
        #1;
        chk("pre_init", init_done, 1'b0);
        tick();
        chk("post_init", init_done, 1'b1);
`endif

        drive(1, 1'b1, 5'd8, 32'hDEADBEEF);
        #1;
        chk("t2_ready", rif.req_ready, 3'b010);
        tick();
        drive(1, 1'b0, 5'd8, 32'hDEADBEEF);
        #1;
        chk_wr("t2", 5'd8, 32'hDEADBEEF, 2'd1);

        drive(2, 1'b1, 5'd3, 32'h33);
        #1;
        chk("ptr2_ready", rif.req_ready, 3'b100);
        tick();
        drive(2, 1'b0, 5'd3, 32'h33);

        drive(0, 1'b1, 5'd17, 32'h100);
        drive(1, 1'b1, 5'd18, 32'h101);
        drive(2, 1'b1, 5'd19, 32'h102);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t3_ready", rif.req_ready, 3'b001 << g_seq[k]);
            if (k > 0) begin
                chk("t3_gid", grant_id, g_seq[k-1]);
                chk("t3_we", regWrite, 1'b1);
            end
            tick();
        end
        rif.req_valid = '0;
        #1;
        chk_wr("t3_last", 5'd19, 32'h102, 2'd2);
        tick();
        chk("idle_we", regWrite, 1'b0);
        chk("idle_addr", writeAddr, 5'd19);
        chk("idle_data", writeData, 32'h102);

        drive(0, 1'b1, 5'd0, 32'd5);
        #1;
        chk("t4_ready", rif.req_ready, 3'b001);
        tick();
        drive(0, 1'b0, 5'd0, 32'd5);
        #1;
        chk("t4_we", regWrite, 1'b0);
        chk("t4_gid", grant_id, 2'd0);
        drive(0, 1'b1, 5'd21, 32'h21);
        drive(2, 1'b1, 5'd22, 32'h22);
        #1;
        chk("t4_ptr1", rif.req_ready, 3'b100);
        tick();
        drive(2, 1'b0, 5'd22, 32'h22);
        #1;
        chk_wr("t4_r2", 5'd22, 32'h22, 2'd2);
        chk("t4_ready0", rif.req_ready, 3'b001);
        tick();
        drive(0, 1'b0, 5'd21, 32'h21);
        #1;
        chk_wr("t4_r0", 5'd21, 32'h21, 2'd0);

        drive(1, 1'b1, 5'd6, 32'h6);
        tick();
        drive(1, 1'b0, 5'd6, 32'h6);
        drive(0, 1'b1, 5'd9, 32'd1);
        drive(2, 1'b1, 5'd9, 32'd2);
        #1;
        chk("t5_ready", rif.req_ready, 3'b100);
        tick();
        drive(2, 1'b0, 5'd9, 32'd2);
        #1;
        chk_wr("t5_first", 5'd9, 32'd2, 2'd2);
        chk("t5_ready0", rif.req_ready, 3'b001);
        tick();
        drive(0, 1'b0, 5'd9, 32'd1);
        #1;
        chk_wr("t5_second", 5'd9, 32'd1, 2'd0);
        tick();
        chk("t5_rf9", rf[9], 32'd1);

        drive(0, 1'b1, 5'd7, 32'h77);
        tick();
        drive(0, 1'b0, 5'd7, 32'h77);
        #1;
        chk("ar_we_before", regWrite, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("ar_we", regWrite, 1'b0);
        chk("ar_addr", writeAddr, '0);
        chk("ar_data", writeData, '0);
        chk("ar_gid", grant_id, '0);
        chk("ar_init", init_done, 1'b0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
